spi_slave: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave. It is the far-end consumer of the SPI bus driven by spi_master (O_spi_sck/O_spi_cs/O_spi_mosi), and it drives that master's I_spi_miso.
- Oversamples the bus in its own I_clk domain. Delivers each received byte on a valid/ready output.
- Takes response bytes through a one-entry TX holding buffer and shifts them out on MISO.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave.sv | 166 ++++++++++++++++
 tb/tb_spi_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 slave: default widths, idle fill byte,
// controller states and a constant-evaluable clog2 for counter sizing.
package spi_pkg;

    localparam int         DATA_W_DEF  = 8;
    localparam logic [7:0] TX_IDLE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus pin, followed by a delay flop
// that yields single-cycle rise/fall strobes in the I_clk domain.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_d,
    output logic O_level,
    output logic O_rise,
    output logic O_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I_d};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign O_level = sync_q[SYNC_STAGES-1];
    assign O_rise  = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign O_fall  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 MSB-first slave, oversampled in the I_clk domain, with a valid/ready
// RX output register and a one-entry TX holding buffer feeding MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = DATA_W'(TX_IDLE_DEF)
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_spi_sck,
    input  logic              I_spi_cs,
    input  logic              I_spi_mosi,
    output logic              O_spi_miso,
    output logic              O_spi_miso_oe,
    input  logic [DATA_W-1:0] I_tx_data,
    input  logic              I_tx_valid,
    output logic              O_tx_ready,
    output logic              O_tx_underrun,
    output logic [DATA_W-1:0] O_rx_data,
    output logic              O_rx_valid,
    input  logic              I_rx_ready,
    output logic              O_rx_overrun
);

    localparam int              CntW    = clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    logic sck_rise, sck_fall, unused_sck_lvl;
    logic cs_lvl, cs_fall, unused_cs_rise;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_d    (I_spi_sck),
        .O_level(unused_sck_lvl),
        .O_rise (sck_rise),
        .O_fall (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_d    (I_spi_cs),
        .O_level(cs_lvl),
        .O_rise (unused_cs_rise),
        .O_fall (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_d    (I_spi_mosi),
        .O_level(mosi_lvl),
        .O_rise (unused_mosi_rise),
        .O_fall (unused_mosi_fall)
    );

    state_e            state_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic [DATA_W-2:0] tx_shift_q;  // bits still to send after the one on MISO
    logic [DATA_W-2:0] rx_shift_q;
    logic [DATA_W-1:0] buf_q;
    logic              buf_full_q;
    logic              miso_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              tx_underrun_q;
    logic              rx_overrun_q;

    logic [DATA_W-1:0] load_d;
    logic [DATA_W-1:0] rx_shift_d;
    logic              load_now;

    always_comb begin
        load_d     = buf_full_q ? buf_q : TX_IDLE;
        rx_shift_d = {rx_shift_q, mosi_lvl};
        load_now   = 1'b0;
        if (!cs_lvl) begin
            load_now = (state_q == StLoad) ||
                       (state_q == StShift && !sck_rise && sck_fall && bit_cnt_q == '0);
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            if (I_tx_valid && !buf_full_q) begin
                buf_q      <= I_tx_data;
                buf_full_q <= 1'b1;
            end
            if (rx_valid_q && I_rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            // A load with an empty buffer leaves buf_full_q to any same-cycle write.
            if (load_now) begin
                tx_shift_q <= load_d[DATA_W-2:0];
                miso_q     <= load_d[DATA_W-1];
                if (buf_full_q) begin
                    buf_full_q <= 1'b0;
                end else begin
                    tx_underrun_q <= 1'b1;
                end
            end
            if (cs_lvl) begin
                state_q   <= StIdle;
                miso_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q <= StLoad;
                        end
                    end
                    StLoad: begin
                        state_q <= StShift;
                    end
                    StShift: begin
                        if (sck_rise) begin
                            rx_shift_q <= rx_shift_d[DATA_W-2:0];
                            if (bit_cnt_q == LastBit) begin
                                bit_cnt_q    <= '0;
                                rx_data_q    <= rx_shift_d;
                                rx_valid_q   <= 1'b1;
                                rx_overrun_q <= rx_valid_q && !I_rx_ready;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else if (sck_fall && bit_cnt_q != '0) begin
                            miso_q     <= tx_shift_q[DATA_W-2];
                            tx_shift_q <= {tx_shift_q[DATA_W-3:0], 1'b0};
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign O_spi_miso    = miso_q;
    assign O_spi_miso_oe = ~cs_lvl;
    assign O_tx_ready    = ~buf_full_q;
    assign O_tx_underrun = tx_underrun_q;
    assign O_rx_data     = rx_data_q;
    assign O_rx_valid    = rx_valid_q;
    assign O_rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 bus master task drives frames and
// immediate assertions compare observed values against hand-computed ones.
module tb_spi_slave;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned un_cnt = 0;
    int unsigned ov_cnt = 0;
    int unsigned vld_cnt = 0;
    logic        vld_prev = 1'b0;
    bit          auto_ack = 1'b1;
    logic        got_valid;
    logic [7:0]  got_data;
    logic [7:0]  mi0, mi1, mi2;
    logic [7:0]  d0, d1, d2;
    int unsigned base_un, base_ov, base_vld;

    always #5 clk = ~clk;

    spi_slave #(
        .DATA_W     (8),
        .SYNC_STAGES(2),
        .TX_IDLE    (8'hFF)
    ) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_spi_sck    (sck),
        .I_spi_cs     (cs),
        .I_spi_mosi   (mosi),
        .O_spi_miso   (miso),
        .O_spi_miso_oe(miso_oe),
        .I_tx_data    (tx_data),
        .I_tx_valid   (tx_valid),
        .O_tx_ready   (tx_ready),
        .O_tx_underrun(tx_underrun),
        .O_rx_data    (rx_data),
        .O_rx_valid   (rx_valid),
        .I_rx_ready   (rx_ready),
        .O_rx_overrun (rx_overrun)
    );

    // Pulses last a full cycle, so sampling on the falling edge sees each one once.
    always @(negedge clk) begin
        if (tx_underrun === 1'b1) un_cnt++;
        if (rx_overrun === 1'b1) ov_cnt++;
        if (rx_valid === 1'b1 && vld_prev !== 1'b1) vld_cnt++;
        vld_prev = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic gap();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Sends nbits of mo MSB-first; with last set, CS rises before the final SCK fall.
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            mi[7-i] = miso;
            if (i == 7) begin
                repeat (3) @(posedge clk);
                #1;
                got_valid = rx_valid;
                got_data  = rx_data;
                @(negedge clk);
                rx_ready = auto_ack;
                @(negedge clk);
                rx_ready = 1'b0;
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (last && i == nbits - 1) begin
                cs = 1'b1;
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    initial begin
        // 1: reset with the bus toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst  = 1'b1;
            sck  = i[0];
            cs   = ~i[0];
            mosi = ~i[1];
        end
        @(posedge clk);
        #1;
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        cs   = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        gap();
        chk("idle_oe", {31'd0, miso_oe}, 32'd0);
        chk("idle_underrun", {31'd0, tx_underrun}, 32'd0);
        chk("idle_overrun", {31'd0, rx_overrun}, 32'd0);
        chk("rst_pulse_un", un_cnt, 32'd0);
        chk("rst_pulse_ov", ov_cnt, 32'd0);

        // 2: single frame, tx 0x3C, rx 0xA5
        tx_write(8'h3C);
        chk("t2_ready_full", {31'd0, tx_ready}, 32'd0);
        base_un = un_cnt;
        cs_low();
        chk("t2_ready_after_load", {31'd0, tx_ready}, 32'd1);
        chk("t2_oe", {31'd0, miso_oe}, 32'd1);
        xfer(8'hA5, 8, 1'b1, mi0);
        chk("t2_valid_3cyc", {31'd0, got_valid}, 32'd1);
        chk("t2_rx_data", {24'd0, got_data}, 32'hA5);
        chk("t2_miso", {24'd0, mi0}, 32'h3C);
        chk("t2_no_underrun", un_cnt - base_un, 32'd0);
        gap();
        chk("t2_oe_off", {31'd0, miso_oe}, 32'd0);

        // 3: three bytes in one frame, buffer fed 0x10 then 0x20
        tx_write(8'h10);
        base_un  = un_cnt;
        base_vld = vld_cnt;
        cs_low();
        tx_write(8'h20);
        xfer(8'h01, 8, 1'b0, mi0);
        d0 = got_data;
        xfer(8'h02, 8, 1'b0, mi1);
        d1 = got_data;
        xfer(8'h03, 8, 1'b1, mi2);
        d2 = got_data;
        gap();
        chk("t3_miso0", {24'd0, mi0}, 32'h10);
        chk("t3_miso1", {24'd0, mi1}, 32'h20);
        chk("t3_miso2", {24'd0, mi2}, 32'hFF);
        chk("t3_rx0", {24'd0, d0}, 32'h01);
        chk("t3_rx1", {24'd0, d1}, 32'h02);
        chk("t3_rx2", {24'd0, d2}, 32'h03);
        chk("t3_underruns", un_cnt - base_un, 32'd1);
        chk("t3_valids", vld_cnt - base_vld, 32'd3);

        // 4: frame aborted after 5 bits, then a full frame
        tx_write(8'h77);
        base_vld = vld_cnt;
        cs_low();
        xfer(8'hC3, 5, 1'b1, mi0);
        gap();
        chk("t4_no_valid", vld_cnt - base_vld, 32'd0);
        chk("t4_rx_valid_low", {31'd0, rx_valid}, 32'd0);
        cs_low();
        xfer(8'h5A, 8, 1'b1, mi0);
        gap();
        chk("t4_rx", {24'd0, got_data}, 32'h5A);
        chk("t4_one_valid", vld_cnt - base_vld, 32'd1);
        chk("t4_miso_idle", {24'd0, mi0}, 32'hFF);

        // 5: consumer stalled across two frames
        auto_ack = 1'b0;
        base_ov  = ov_cnt;
        cs_low();
        xfer(8'h11, 8, 1'b1, mi0);
        gap();
        chk("t5_first_no_ovr", ov_cnt - base_ov, 32'd0);
        cs_low();
        xfer(8'h22, 8, 1'b1, mi0);
        gap();
        chk("t5_overrun_once", ov_cnt - base_ov, 32'd1);
        chk("t5_rx_data", {24'd0, rx_data}, 32'h22);
        chk("t5_valid_held", {31'd0, rx_valid}, 32'd1);
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_valid_cleared", {31'd0, rx_valid}, 32'd0);
        @(negedge clk);
        rx_ready = 1'b0;
        auto_ack = 1'b1;

        // 6: reset mid-frame, then a fresh frame with an empty buffer
        base_vld = vld_cnt;
        cs_low();
        xfer(8'hF0, 4, 1'b0, mi0);
        @(negedge clk);
        rst = 1'b1;
        cs  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base_un = un_cnt;
        gap();
        chk("t6_no_valid", vld_cnt - base_vld, 32'd0);
        chk("t6_no_underrun", un_cnt - base_un, 32'd0);
        chk("t6_tx_ready", {31'd0, tx_ready}, 32'd1);
        cs_low();
        xfer(8'h96, 8, 1'b1, mi0);
        gap();
        chk("t6_rx", {24'd0, got_data}, 32'h96);
        chk("t6_valid", {31'd0, got_valid}, 32'd1);
        chk("t6_miso_idle", {24'd0, mi0}, 32'hFF);
        chk("t6_underrun", un_cnt - base_un, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
